chain_eval_scheduler: RTL and testbench

Sequencing controller for the three-stage dependency-chain datapath (`i1 = a & b`, `i2 = i1 | a`, `i3 = i2 ^ b`, `result = i3`). Several requesters share one chain evaluator. The block arbitrates among them round-robin, evaluates one stage per cycle, and returns the result tagged with the requester ID over a valid/ready response channel. It sits between the requester ports and downstream consumers, and keeps a completed-transaction counter for debug.

---
 rtl/chain_eval_scheduler.sv | 111 +++++++++++
 tb/tb_chain_eval_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chain_eval_scheduler.sv
// rtl/chain_eval_scheduler.sv - round-robin shared evaluator for the three-stage a/b dependency chain
module chain_eval_scheduler #(
    parameter int WIDTH   = 8,
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [WIDTH-1:0]         rsp_result,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [15:0]              done_count
);

    typedef enum logic [2:0] {IDLE, S1, S2, S3, RESP} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_found;
    logic [WIDTH-1:0]  sel_a, sel_b;
    logic [WIDTH-1:0]  a_q, b_q, i1_q, i2_q, i3_q;
    logic [ID_W-1:0]   id_q;
    logic              accept;

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int              tmp;
        logic [ID_W-1:0] idx;
        tmp       = 0;
        idx       = '0;
        gnt_found = 1'b0;
        gnt_id    = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            tmp = int'(rr_ptr) + k;
            if (tmp >= NUM_REQ) tmp = tmp - NUM_REQ;
            idx = ID_W'(tmp);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_id    = idx;
                sel_a     = req_a[idx*WIDTH +: WIDTH];
                sel_b     = req_b[idx*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (!rst && !flush && state_q == IDLE && gnt_found) req_ready[gnt_id] = 1'b1;
    end

    assign accept = |req_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= '0;
            i1_q       <= '0;
            i2_q       <= '0;
            i3_q       <= '0;
            done_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q    <= sel_a;
                b_q    <= sel_b;
                id_q   <= gnt_id;
                rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
            end
            case (state_q)
                S1:      i1_q <= a_q & b_q;
                S2:      i2_q <= i1_q | a_q;
                S3:      i3_q <= i2_q ^ b_q;
                default: ;
            endcase
            // A response taken in the same cycle as a flush still counts as delivered.
            if (state_q == RESP && rsp_ready) done_count <= done_count + 16'd1;
        end
    end

    assign rsp_valid  = (state_q == RESP);
    assign rsp_result = i3_q;
    assign rsp_id     = id_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_chain_eval_scheduler.sv
// tb/tb_chain_eval_scheduler.sv - directed and randomized checks of chain_eval_scheduler against a transaction model
module tb_chain_eval_scheduler;

    localparam int W = 8;
    localparam int N = 2;

    logic          clk = 1'b0;
    logic          rst, flush, rsp_ready;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*W-1:0] req_a, req_b;
    logic          rsp_valid, busy;
    logic [W-1:0]  rsp_result;
    logic [0:0]    rsp_id;
    logic [15:0]   done_count;

    chain_eval_scheduler #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_id(rsp_id),
        .busy(busy), .done_count(done_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a job is either absent or has an age counted in cycles since acceptance.
    bit          model_on = 0;
    bit          m_busy   = 0;
    int          m_age    = 0;
    logic [W-1:0] m_res   = '0;
    int          m_id     = 0;
    int          m_ptr    = 0;
    logic [15:0] m_cnt    = '0;

    function automatic logic [W-1:0] chain(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] i1, i2;
        i1 = a & b;
        i2 = i1 | a;
        return i2 ^ b;
    endfunction

    always @(negedge clk) begin
        logic [N-1:0] er;
        int w;
        if (model_on) begin
            er = '0;
            w  = -1;
            if (!rst && !m_busy && !flush)
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) er[w] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("busy", busy, m_busy);
            chk("rsp_valid", rsp_valid, (m_busy && m_age == 4));
            chk("done_count", done_count, m_cnt);
            if (m_busy && m_age == 4) begin
                chk("rsp_result", rsp_result, m_res);
                chk("rsp_id", rsp_id, m_id);
            end
            if (rst) begin
                m_busy = 0; m_ptr = 0; m_cnt = '0;
            end else if (m_busy) begin
                if (m_age == 4) begin
                    if (rsp_ready) begin m_cnt = m_cnt + 16'd1; m_busy = 0; end
                    else if (flush) m_busy = 0;
                end else if (flush) m_busy = 0;
                else m_age++;
            end else if (w >= 0) begin
                m_res  = chain(req_a[w*W +: W], req_b[w*W +: W]);
                m_id   = w;
                m_ptr  = (w + 1) % N;
                m_busy = 1;
                m_age  = 1;
            end
        end
    end

    task automatic wait_valid(input string name, output int edges);
        edges = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) return;
            @(posedge clk); #1;
            edges++;
        end
        chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1; flush = 0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 0;
        repeat (2) @(posedge clk);
        #1 model_on = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("reset_result", rsp_result, 0);
        chk("reset_id", rsp_id, 0);

        // Single request: a=F0, b=3C -> CC after 4 edges
        @(posedge clk); #1;
        req_a[7:0] = 8'hF0; req_b[7:0] = 8'h3C; req_valid = 2'b01;
        @(posedge clk); #1 req_valid = '0;
        n = 1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rsp_valid) break;
            @(posedge clk); #1;
            n++;
        end
        chk("single_latency", n, 4);
        chk("single_result", rsp_result, 8'hCC);
        chk("single_id", rsp_id, 0);
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        chk("single_count", done_count, 1);

        // Round robin from a fresh reset
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        req_a = {8'h0F, 8'hAA}; req_b = {8'hFF, 8'h55};
        req_valid = 2'b11; rsp_ready = 1;
        for (int i = 0; i < 4; i++) begin
            wait_valid("rr", n);
            chk("rr_id", rsp_id, i % 2);
            chk("rr_result", rsp_result, (i % 2) ? 8'hF0 : 8'hFF);
            @(posedge clk); #1;
        end
        req_valid = '0; rsp_ready = 0;
        @(negedge clk);
        chk("rr_count", done_count, 4);

        // Back-pressure on requester 1
        @(posedge clk); #1;
        req_a[15:8] = 8'h12; req_b[15:8] = 8'h34; req_valid = 2'b10;
        @(posedge clk); #1 req_valid = '0;
        wait_valid("bp", n);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1 req_valid = 2'b11;
            @(negedge clk);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_result", rsp_result, 8'h26);
            chk("bp_id", rsp_id, 1);
            chk("bp_ready", req_ready, 0);
        end
        @(posedge clk); #1 req_valid = '0; rsp_ready = 1;
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        chk("bp_count", done_count, 5);

        // Flush in S2, then flush in IDLE against a request
        @(posedge clk); #1 req_valid = 2'b01;
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk); #1 flush = 1;
        @(posedge clk); #1 flush = 0;
        @(negedge clk);
        chk("flush_busy", busy, 0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("flush_novalid", rsp_valid, 0);
        end
        chk("flush_count", done_count, 5);
        @(posedge clk); #1 req_valid = 2'b10; flush = 1;
        @(negedge clk);
        chk("flush_idle_ready", req_ready, 0);
        @(posedge clk); #1 flush = 0; req_valid = '0;
        @(negedge clk);
        chk("flush_noaccept", busy, 0);

        // Reset in S3 with rr_ptr = 1
        @(posedge clk); #1 req_valid = 2'b01;
        @(posedge clk); #1 req_valid = '0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_result", rsp_result, 0);
        chk("rst_id", rsp_id, 0);
        chk("rst_count", done_count, 0);
        @(posedge clk); #1 req_valid = 2'b11;
        @(negedge clk);
        chk("rst_grant", req_ready, 2'b01);
        @(posedge clk); #1 req_valid = '0; rsp_ready = 1;
        wait_valid("rst", n);
        chk("rst_next_id", rsp_id, 0);
        @(posedge clk); #1 rsp_ready = 0;

        // Counter wrap via preload
        @(posedge clk); #2;
        force dut.done_count = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(posedge clk); #2 release dut.done_count;
        @(posedge clk); #1 req_valid = 2'b10; rsp_ready = 1;
        @(posedge clk); #1 req_valid = '0;
        wait_valid("wrap", n);
        @(posedge clk); #1 rsp_ready = 0;
        @(negedge clk);
        chk("wrap_count", done_count, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            rst       = ($urandom_range(0, 199) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            rsp_ready = $urandom_range(0, 1);
            req_valid = N'($urandom_range(0, 3));
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
        end
        @(posedge clk); #1 rst = 0; flush = 0; req_valid = '0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
